// File: rtl/ram_rr_arbiter_pkg.sv
// Shared types and constants for the two-client RAM round-robin arbiter.
// Used by the arbiter, its requester interface and the grant sub-module.
package ram_rr_arbiter_pkg;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_idx_e;

  // Clear FSM encoding, kept as plain constants for legacy tool flows.
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/ram_rr_arbiter_if.sv
// One requester port of the shared-RAM arbiter.
// Handshake: the client raises req (with we/adr/dat_w stable) and holds it until gnt is
// seen high in the same cycle; req & gnt means the access is issued that cycle. A granted
// read returns rvalid with dat_r exactly one cycle later; dat_r is 0 whenever rvalid is 0.
interface ram_rr_arbiter_if
  import ram_rr_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] dat_r;

  modport master (
    output req, we, adr, dat_w,
    input  gnt, rvalid, dat_r
  );

  modport slave (
    input  req, we, adr, dat_w,
    output gnt, rvalid, dat_r
  );

endinterface

// File: rtl/ram_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant. The pointer names the side that wins a tie and
// moves to the losing side after every grant, so a continuous tie alternates.
module rr_arb2
  import ram_rr_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_idx_e   ptr_q, ptr_d;
  logic [1:0] gnt;

  always_comb begin
    gnt = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
      end else begin
        gnt = req_i;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = REQ_B;
    end else if (gnt[1]) begin
      ptr_d = REQ_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt;

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one single-port synchronous RAM between requesters A and B. After reset
// the RAM is cleared to CLEAR_VAL, then accesses are granted round-robin.
module ram_rr_arbiter
  import ram_rr_arbiter_pkg::*;
#(
  parameter int            AW        = DEF_AW,
  parameter int            DW        = DEF_DW,
  parameter logic [DW-1:0] CLEAR_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  ram_rr_arbiter_if.slave a,
  ram_rr_arbiter_if.slave b,
  output logic [AW-1:0]   mem_adr,
  output logic [DW-1:0]   mem_dat_w,
  output logic            mem_we,
  input  logic [DW-1:0]   mem_dat_r,
  output logic            init_done,
  output logic [0:0]      dbg_state_o
);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          a_rv_q, a_rv_d;
  logic          b_rv_q, b_rv_d;
  logic [1:0]    gnt;
  logic          a_rvalid, b_rvalid;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == ST_RUN),
    .req_i ({b.req, a.req}),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_dat_w = '0;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_adr   = cnt_q;
      mem_dat_w = CLEAR_VAL;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == {AW{1'b1}}) begin
        state_d = ST_RUN;
      end
    end else if (gnt[0]) begin
      mem_we    = a.we;
      mem_adr   = a.adr;
      mem_dat_w = a.dat_w;
    end else if (gnt[1]) begin
      mem_we    = b.we;
      mem_adr   = b.adr;
      mem_dat_w = b.dat_w;
    end
  end

  assign a_rv_d = gnt[0] & ~a.we;
  assign b_rv_d = gnt[1] & ~b.we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_rv_q  <= a_rv_d;
      b_rv_q  <= b_rv_d;
    end
  end

  // A read in flight when reset arrives must not surface its data.
  assign a_rvalid = a_rv_q & ~rst;
  assign b_rvalid = b_rv_q & ~rst;

  assign a.gnt    = gnt[0];
  assign b.gnt    = gnt[1];
  assign a.rvalid = a_rvalid;
  assign b.rvalid = b_rvalid;
  assign a.dat_r  = a_rvalid ? mem_dat_r : '0;
  assign b.dat_r  = b_rvalid ? mem_dat_r : '0;

  assign init_done   = (state_q == ST_RUN);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: behavioural RAM, cycle model of clear/arbitration,
// and per-requester queues of expected read data.
module tb_ram_rr_arbiter;

  localparam int            AW    = 4;
  localparam int            DW    = 8;
  localparam int            DEPTH = 1 << AW;
  localparam logic [DW-1:0] CLR   = 8'h00;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_rr_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
  ram_rr_arbiter_if #(.AW(AW), .DW(DW)) b_if ();

  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_dat_w;
  logic          mem_we;
  logic [DW-1:0] mem_dat_r;
  logic          init_done;
  logic [0:0]    dbg_state;

  ram_rr_arbiter #(.AW(AW), .DW(DW), .CLEAR_VAL(CLR)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a_if.slave),
    .b           (b_if.slave),
    .mem_adr     (mem_adr),
    .mem_dat_w   (mem_dat_w),
    .mem_we      (mem_we),
    .mem_dat_r   (mem_dat_r),
    .init_done   (init_done),
    .dbg_state_o (dbg_state)
  );

  // RAM with registered read address
  logic          preload = 1'b1;
  logic [DW-1:0] ram [DEPTH];
  logic [AW-1:0] ram_adr_q;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'hFF;
    end else if (mem_we) begin
      ram[mem_adr] <= mem_dat_w;
    end
    ram_adr_q <= mem_adr;
  end
  assign mem_dat_r = ram[ram_adr_q];

  // model + scoreboard
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            chk_en  = 1'b0;
  bit            m_run   = 1'b0;
  int            m_cnt   = 0;
  bit            m_ptr   = 1'b0;
  bit            m_pend_a = 1'b0;
  bit            m_pend_b = 1'b0;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, then advance the model.
  task automatic step(input bit r,
                      input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    bit            ega, egb, erva, ervb, ewe;
    logic [AW-1:0] eadr;
    logic [DW-1:0] edat, v;
    @(posedge clk);
    #1;
    rst = r;
    a_if.req = ar; a_if.we = aw; a_if.adr = aa; a_if.dat_w = ad;
    b_if.req = br; b_if.we = bw; b_if.adr = ba; b_if.dat_w = bd;
    @(negedge clk);
    ega = m_run && ar && (!br || !m_ptr);
    egb = m_run && br && !ega;
    if (!m_run) begin
      ewe = 1'b1; eadr = m_cnt[AW-1:0]; edat = CLR;
    end else if (ega) begin
      ewe = aw; eadr = aa; edat = ad;
    end else if (egb) begin
      ewe = bw; eadr = ba; edat = bd;
    end else begin
      ewe = 1'b0; eadr = '0; edat = '0;
    end
    erva = m_pend_a && !r;
    ervb = m_pend_b && !r;
    if (chk_en) begin
      check("a_gnt", a_if.gnt, ega);
      check("b_gnt", b_if.gnt, egb);
      check("mem_we", mem_we, ewe);
      check("mem_adr", mem_adr, eadr);
      check("mem_dat_w", mem_dat_w, edat);
      check("init_done", init_done, m_run);
      check("state", dbg_state, m_run);
      check("a_rvalid", a_if.rvalid, erva);
      check("b_rvalid", b_if.rvalid, ervb);
    end
    if (m_pend_a && exp_a_q.size() > 0) begin
      v = exp_a_q.pop_front();
      if (chk_en && erva) check("a_dat_r", a_if.dat_r, v);
    end
    if (m_pend_b && exp_b_q.size() > 0) begin
      v = exp_b_q.pop_front();
      if (chk_en && ervb) check("b_dat_r", b_if.dat_r, v);
    end
    if (chk_en && !erva) check("a_dat_r_idle", a_if.dat_r, 0);
    if (chk_en && !ervb) check("b_dat_r_idle", b_if.dat_r, 0);
    if (r) begin
      m_run = 1'b0; m_cnt = 0; m_ptr = 1'b0; m_pend_a = 1'b0; m_pend_b = 1'b0;
    end else if (!m_run) begin
      m_mem[m_cnt] = CLR;
      m_pend_a = 1'b0; m_pend_b = 1'b0;
      if (m_cnt == DEPTH - 1) begin
        m_run = 1'b1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      m_pend_a = ega && !aw;
      m_pend_b = egb && !bw;
      if (m_pend_a) exp_a_q.push_back(m_mem[aa]);
      if (m_pend_b) exp_b_q.push_back(m_mem[ba]);
      if (ega && aw) m_mem[aa] = ad;
      if (egb && bw) m_mem[ba] = bd;
      if (ega) m_ptr = 1'b1;
      else if (egb) m_ptr = 1'b0;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Clear cycles with both clients asserting reads, which must not be granted.
  task automatic clear_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 4'd1, 0, 1, 0, 4'd2, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hFF;
    a_if.req = 0; a_if.we = 0; a_if.adr = 0; a_if.dat_w = 0;
    b_if.req = 0; b_if.we = 0; b_if.adr = 0; b_if.dat_w = 0;

    // power-up: RAM holds 0xFF, first reset cycle leaves DUT state unknown
    do_reset();
    preload = 1'b0;
    chk_en  = 1'b1;
    do_reset();
    for (int i = 0; i < DEPTH; i++) idle();
    step(0, 1, 0, 4'd7, 0, 0, 0, 0, 0);
    idle();

    // simultaneous writes in the first RUN cycle, then read-back
    do_reset();
    clear_cycles(DEPTH);
    step(0, 1, 1, 4'd3, 8'h5A, 1, 1, 4'd4, 8'hC3);
    step(0, 0, 0, 0, 0, 1, 1, 4'd4, 8'hC3);
    step(0, 1, 0, 4'd3, 0, 1, 0, 4'd4, 0);
    step(0, 0, 0, 0, 0, 1, 0, 4'd4, 0);
    idle();

    // continuous double read requests alternate every cycle
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, AW'($urandom_range(0, DEPTH - 1)), 0,
              1, 0, AW'($urandom_range(0, DEPTH - 1)), 0);
    end
    idle();

    // write by A followed immediately by a read of the same word by B
    step(0, 1, 1, 4'd9, 8'h11, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 4'd9, 0);
    idle();

    // random traffic
    for (int i = 0; i < 60; i++) begin
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 255)));
    end
    idle();

    // reset arriving mid-clear restarts from address 0
    do_reset();
    clear_cycles(8);
    do_reset();
    clear_cycles(DEPTH);
    idle();

    // in-flight read dropped by reset; pointer returns to A
    step(0, 1, 0, 4'd5, 0, 0, 0, 0, 0);
    do_reset();
    clear_cycles(DEPTH);
    step(0, 1, 0, 4'd6, 0, 1, 0, 4'd8, 0);
    step(0, 0, 0, 0, 0, 1, 0, 4'd8, 0);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
